multi_button_controller: RTL and testbench
==========================================

Name: multi_button_controller

Overview:
- N-channel button front end. It synchronises each raw button and debounces it against an internal millisecond tick. It then produces one press pulse, one toggle state bit and a long-press flag per channel.
- It supersedes the fixed two-button left/right toggle controller. The channel count, tick rate, debounce window and long-press threshold are parametrised, and a per-channel toggle/momentary mode is added.
- It sits between the board pushbuttons and the set/mode logic of the clock datapath.

Parameters:
- NUM_BTN, 2, number of button channels (1..16).
- TICK_DIV, 100000, clk cycles per debounce tick (100 MHz -> 1 kHz).
- DEB_TICKS, 10, consecutive stable ticks required to accept a new level (2..255).
- LONG_TICKS, 1000, ticks a debounced press must be held to raise long_press (> DEB_TICKS, < 65536).
- INIT_STATE, {NUM_BTN{1'b0}}, value of state after reset.

Ports:
- clk, input, 1, system clock; the only clock.
- reset, input, 1, asynchronous active-high reset.
- btn, input, NUM_BTN, raw asynchronous button levels; 1 = pressed.
- mode, input, NUM_BTN, per channel: 0 = toggle, 1 = momentary (state follows debounced level).
- set, input, 1, synchronous load enable.
- set_value, input, NUM_BTN, value loaded into state when set = 1.
- state, output, NUM_BTN, toggle or momentary state per channel.
- press, output, NUM_BTN, one-clk pulse on each accepted press (debounced 0->1).
- long_press, output, NUM_BTN, one-clk pulse when a press has been held LONG_TICKS.
- tick, output, 1, one-clk debounce tick, exported for other timers.

Behaviour:
- Reset (async, any time):
  - state = INIT_STATE; press = 0; long_press = 0; tick = 0.
  - Prescaler = 0. All debounce counters = 0. All debounced levels = 0. Hold counters = 0. Sync flops = 0.
- Synchroniser: a 2-flop chain per channel on btn.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick = 1 for exactly one clk when the count wraps to 0. The first tick occurs TICK_DIV clks after reset release.
- Debounce, per channel, evaluated only on tick:
  - If the synced level equals the debounced level, the counter = 0.
  - Otherwise the counter increments. When it reaches DEB_TICKS-1 on a tick, the debounced level flips and the counter = 0.
  - An accepted edge therefore needs DEB_TICKS consecutive disagreeing ticks. Any agreeing tick restarts the count, so bounce shorter than the window is rejected.
- Press detection:
  - press[i] = 1 on the clk cycle after the debounced level goes 0->1, for one clk.
  - A release (1->0) produces no pulse.
- Long press:
  - A hold counter increments on each tick while debounced = 1 and saturates at LONG_TICKS. It clears when debounced = 0.
  - long_press[i] pulses one clk when the counter first reaches LONG_TICKS. It fires once per hold; there is no repeat.
- State update, registered, priority high to low:
  1. set = 1 -> state = set_value. Any press in the same cycle is ignored for toggle channels.
  2. mode[i] = 1 -> state[i] = debounced level.
  3. mode[i] = 0 and press[i] -> state[i] inverts.
- Latency: clean btn edge to press pulse is at most 2 (sync) + DEB_TICKS*TICK_DIV + TICK_DIV + 1 clks.
- Simultaneous presses on different channels are independent. All pulses may coincide.
- A mode change mid-hold takes effect on the next clk. Switching to toggle does not create a press.
- Widths:
  - Debounce counter is ceil(log2(DEB_TICKS)) bits.
  - Hold counter is ceil(log2(LONG_TICKS+1)) bits.
  - No counter wraps; the hold counter saturates.

Decomposition:
- Package button_pkg holds:
  - Default constants: TICK_DIV_1KHZ = 100000, DEB_TICKS_DEFAULT = 10, LONG_TICKS_DEFAULT = 1000.
  - The mode encoding localparams MODE_TOGGLE = 0 and MODE_MOMENTARY = 1.
- Sub-module button_channel, instantiated NUM_BTN times by a generate loop, holds sync, debounce, edge detect, hold counter and the state bit.
- The prescaler stays in the top level and is shared by all channels.

Test Plan (bench with TICK_DIV = 4, DEB_TICKS = 3, LONG_TICKS = 8, NUM_BTN = 2):
- Reset then idle 100 clks -> state = 00, press = 00, long_press = 00, tick every 4th clk.
- btn[0] held high, mode = 00 -> exactly one press[0] pulse within 2+12+4+1 clks, and state = 01. Release for 20 clks and press again -> state = 00.
- btn[1] bounces 1,0,1,0 with one tick per level, then holds 1 -> no press during the bounce. One press[1] after 3 stable ticks. state[1] = 1.
- btn[0] held 50 clks, mode[0] = 1 -> state[0] = 1 while debounced high. long_press[0] pulses exactly once, 8 ticks after acceptance. state[0] = 0 after release is debounced.
- set = 1 with set_value = 10 on the same clk as press[0] -> state = 10, and the toggle is dropped.
- reset asserted mid-hold, between ticks -> all outputs are 0 and state = INIT_STATE immediately, without waiting for a clk edge. After release, a press requires the full debounce window again.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants and helpers for the multi-channel button front end.
package button_pkg;

    localparam int TICK_DIV_1KHZ      = 100000;
    localparam int DEB_TICKS_DEFAULT  = 10;
    localparam int LONG_TICKS_DEFAULT = 1000;

    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, tick-based debounce, press edge,
// long-press hold counter and the toggle/momentary state bit.
module button_channel
    import button_pkg::*;
#(
    parameter int   DEB_TICKS  = DEB_TICKS_DEFAULT,
    parameter int   LONG_TICKS = LONG_TICKS_DEFAULT,
    parameter logic INIT_STATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic mode_i,
    input  logic set_i,
    input  logic set_value_i,
    input  logic tick_i,
    output logic state_o,
    output logic press_o,
    output logic long_press_o
);

    localparam int DW = cnt_width(DEB_TICKS);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

    logic [1:0]    sync_q, sync_d;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic          state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            hold_q  <= '0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            state_q <= INIT_STATE;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            hold_q  <= hold_d;
            press_q <= press_d;
            long_q  <= long_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync_d = {sync_q[0], btn_i};
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (tick_i) begin
            if (sync_q[1] == deb_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DEB_LAST) begin
                deb_d  = ~deb_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        // Hold count saturates so long_press fires only once per hold.
        hold_d = hold_q;
        if (!deb_q) begin
            hold_d = '0;
        end else if (tick_i && hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end
        long_d  = deb_q & tick_i & (hold_q == HOLD_PRE);
        press_d = deb_d & ~deb_q;

        priority case (1'b1)
            set_i:                     state_d = set_value_i;
            mode_i == MODE_MOMENTARY:  state_d = deb_q;
            press_q:                   state_d = ~state_q;
            default:                   state_d = state_q;
        endcase
    end

    assign state_o      = state_q;
    assign press_o      = press_q;
    assign long_press_o = long_q;

endmodule

// File: rtl/multi_button_controller.sv
// N-channel button front end: shared tick prescaler feeding one
// debounce/press/long-press channel per button.
module multi_button_controller
    import button_pkg::*;
#(
    parameter int                 NUM_BTN    = 2,
    parameter int                 TICK_DIV   = TICK_DIV_1KHZ,
    parameter int                 DEB_TICKS  = DEB_TICKS_DEFAULT,
    parameter int                 LONG_TICKS = LONG_TICKS_DEFAULT,
    parameter logic [NUM_BTN-1:0] INIT_STATE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_BTN-1:0] mode,
    input  logic               set,
    input  logic [NUM_BTN-1:0] set_value,
    output logic [NUM_BTN-1:0] state,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] long_press,
    output logic               tick
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEB_TICKS  (DEB_TICKS),
            .LONG_TICKS (LONG_TICKS),
            .INIT_STATE (INIT_STATE[i])
        ) u_ch (
            .clk          (clk),
            .rst          (reset),
            .btn_i        (btn[i]),
            .mode_i       (mode[i]),
            .set_i        (set),
            .set_value_i  (set_value[i]),
            .tick_i       (tick_q),
            .state_o      (state[i]),
            .press_o      (press[i]),
            .long_press_o (long_press[i])
        );
    end

endmodule

// File: tb/tb_multi_button_controller.sv
// Directed scenarios plus random stimulus, every cycle compared
// against a tick/count-based reference model of the channel rules.
module tb_multi_button_controller;

    localparam int NB = 2;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int LT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn, mode, set_value;
    logic          set;
    logic [NB-1:0] state, press, long_press;
    logic          tick;

    multi_button_controller #(
        .NUM_BTN    (NB),
        .TICK_DIV   (TD),
        .DEB_TICKS  (DT),
        .LONG_TICKS (LT),
        .INIT_STATE (2'b00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .mode       (mode),
        .set        (set),
        .set_value  (set_value),
        .state      (state),
        .press      (press),
        .long_press (long_press),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycle phase, sync pipeline, counts of
    // disagreeing ticks and held ticks.
    int            m_pc;
    logic          m_tick;
    logic [NB-1:0] m_s1, m_s2, m_deb, m_press, m_long, m_state;
    int            m_dis [NB];
    int            m_hold[NB];
    int            n_press[NB];
    int            n_long [NB];
    int            n_tick;

    task automatic m_reset();
        m_pc = 0; m_tick = 0;
        m_s1 = '0; m_s2 = '0; m_deb = '0;
        m_press = '0; m_long = '0; m_state = '0;
        for (int i = 0; i < NB; i++) begin
            m_dis[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic clr_counts();
        n_tick = 0;
        for (int i = 0; i < NB; i++) begin
            n_press[i] = 0; n_long[i] = 0;
        end
    endtask

    task automatic step();
        logic          t_tick;
        logic [NB-1:0] t_deb, t_press, t_long, t_state;
        int            t_dis[NB];
        int            t_hold[NB];
        t_tick = (m_pc == TD - 1);
        for (int i = 0; i < NB; i++) begin
            t_deb[i] = m_deb[i];
            t_dis[i] = m_dis[i];
            if (m_tick) begin
                if (m_s2[i] != m_deb[i]) begin
                    t_dis[i] = m_dis[i] + 1;
                    if (t_dis[i] == DT) begin
                        t_deb[i] = ~m_deb[i];
                        t_dis[i] = 0;
                    end
                end else begin
                    t_dis[i] = 0;
                end
            end
            t_press[i] = !m_deb[i] && t_deb[i];
            if (!m_deb[i]) t_hold[i] = 0;
            else if (m_tick && m_hold[i] < LT) t_hold[i] = m_hold[i] + 1;
            else t_hold[i] = m_hold[i];
            t_long[i] = (t_hold[i] == LT) && (m_hold[i] != LT);
            if (set) t_state[i] = set_value[i];
            else if (mode[i]) t_state[i] = m_deb[i];
            else if (m_press[i]) t_state[i] = ~m_state[i];
            else t_state[i] = m_state[i];
        end
        @(posedge clk);
        #1;
        m_s2 = m_s1; m_s1 = btn;
        m_pc = (m_pc + 1) % TD; m_tick = t_tick;
        m_deb = t_deb; m_press = t_press; m_long = t_long;
        m_state = t_state;
        for (int i = 0; i < NB; i++) begin
            m_dis[i] = t_dis[i]; m_hold[i] = t_hold[i];
            n_press[i] += int'(press[i]);
            n_long[i]  += int'(long_press[i]);
        end
        n_tick += int'(tick);
        chk("state", 32'(state), 32'(m_state));
        chk("press", 32'(press), 32'(m_press));
        chk("long",  32'(long_press), 32'(m_long));
        chk("tick",  32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int lat;

    initial begin
        reset = 1'b1; btn = '0; mode = '0; set = 1'b0; set_value = '0;
        m_reset();
        clr_counts();
        #1;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_press", 32'(press), 32'h0);
        chk("rst_long",  32'(long_press), 32'h0);
        chk("rst_tick",  32'(tick), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();

        // Idle
        clr_counts();
        run(100);
        chk("idle_ticks", 32'(n_tick), 32'd25);
        chk("idle_press", 32'(n_press[0] + n_press[1]), 32'd0);

        // Toggle on btn[0]
        clr_counts();
        btn = 2'b01;
        run(2 + 12 + 4 + 1);
        chk("tog_press_cnt", 32'(n_press[0]), 32'd1);
        step();
        chk("tog_state1", 32'(state), 32'h1);
        btn = 2'b00;
        run(20);
        btn = 2'b01;
        run(24);
        chk("tog_state2", 32'(state), 32'h0);
        btn = 2'b00;
        run(24);

        // Bounce on btn[1], one tick per level
        clr_counts();
        btn = 2'b10; run(4);
        btn = 2'b00; run(4);
        btn = 2'b10; run(4);
        btn = 2'b00; run(4);
        chk("bounce_none", 32'(n_press[1]), 32'd0);
        btn = 2'b10;
        run(24);
        chk("bounce_one", 32'(n_press[1]), 32'd1);
        chk("bounce_st1", 32'(state[1]), 32'd1);
        btn = 2'b00;
        run(24);

        // Momentary with long press
        clr_counts();
        mode = 2'b01;
        btn = 2'b01;
        run(56);
        chk("mom_state", 32'(state[0]), 32'd1);
        chk("mom_long", 32'(n_long[0]), 32'd1);
        btn = 2'b00;
        run(24);
        chk("mom_rel", 32'(state[0]), 32'd0);
        chk("mom_long2", 32'(n_long[0]), 32'd1);

        // Set collides with press[0]
        mode = 2'b00;
        btn = 2'b01;
        lat = 0;
        while (press[0] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("set_press_seen", 32'(press[0]), 32'd1);
        set = 1'b1; set_value = 2'b10;
        step();
        set = 1'b0;
        chk("set_wins", 32'(state), 32'h2);
        run(6);
        chk("set_hold", 32'(state), 32'h2);

        // Async reset mid-hold, between edges
        run(10);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_press", 32'(press), 32'h0);
        chk("arst_long",  32'(long_press), 32'h0);
        chk("arst_tick",  32'(tick), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        lat = 0;
        while (press[0] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("arst_relat_lo", 32'(lat >= DT * TD), 32'd1);
        chk("arst_relat_hi", 32'(lat <= 2 + DT * TD + TD + 1), 32'd1);
        btn = '0;
        run(24);

        // Random traffic
        for (int seg = 0; seg < 60; seg++) begin
            btn  = NB'($urandom);
            mode = NB'($urandom);
            set_value = NB'($urandom);
            set  = ($urandom_range(0, 7) == 0);
            step();
            set = 1'b0;
            run($urandom_range(1, 40));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
